// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Optional PIPE_PERF_CNT_EN adds stall and branch-squash performance counters.
module pipe_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       branch_taken,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_bubble,
  output logic       mem_error
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int unsigned InitW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {StInit, StRun, StMemWait, StError} stateT;

  stateT            state;
  logic [InitW-1:0] initCnt;
  logic [WaitW-1:0] waitCnt;
  logic             memErrorQ;
  logic             loadUse;
  logic             memStall;
  logic             holdMem;

  assign loadUse = ex_memread && (ex_rd != 5'd0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign memStall = mem_req && !mem_ready;
  // In MEM_WAIT only mem_ready matters; upstream is frozen so other inputs are stale.
  assign holdMem = (state == StRun) ? memStall : !mem_ready;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    mem_error    = memErrorQ;
    unique case (state)
      StInit, StError: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        memwb_bubble = 1'b1;
      end
      StRun, StMemWait: begin
        if (holdMem) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          idex_en      = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (loadUse) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StInit;
      initCnt   <= '0;
      waitCnt   <= '0;
      memErrorQ <= 1'b0;
    end else begin
      case (state)
        StInit: begin
          if (initCnt == InitW'(INIT_CYCLES - 1)) begin
            state <= StRun;
          end else begin
            initCnt <= initCnt + 1'b1;
          end
        end
        StRun: begin
          if (memStall) begin
            state   <= StMemWait;
            waitCnt <= WaitW'(1);
          end
        end
        StMemWait: begin
          if (mem_ready) begin
            state   <= StRun;
            waitCnt <= '0;
          end else if (waitCnt == WaitW'(MEM_TIMEOUT)) begin
            state     <= StError;
            memErrorQ <= 1'b1;
          end else if (waitCnt != '1) begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        StError: memErrorQ <= 1'b1;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // A branch squash is the only case with PC advancing while IF/ID is flushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_en && (state == StRun || state == StMemWait)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (pc_en && ifid_flush) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
